// File: rtl/comparador_pkg.sv
// Shared constants and FSM encoding for the serial driver of the
// right-to-left comparison cell.
package comparador_pkg;

  localparam int WIDTH_DEF = 8;

  // Cell state variable: a = "A <= B so far", b = "A > B so far".
  localparam logic ESTADO_A = 1'b1;
  localparam logic ESTADO_B = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_bits.sv
// Bit counter for the serial comparison; raises o_tc when it holds WIDTH-1.
module contador_bits #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/comparador_serial.sv
// Serial driver for the combinational comparison cell: shifts A/B out LSB first,
// keeps the cell state in r_p and reports A <= B. Optional igual via COMPARADOR_SERIAL_IGUALDAD_EN.
module comparador_serial
  import comparador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ai_o,
  output logic             Bi_o,
  output logic             p_o,
  input  logic             P_i,
  output logic             busy,
  output logic             done,
  output logic             menor_igual,
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
  output logic             igual,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level sampled on a rising edge only while IDLE;
  // done pulses for one cycle and menor_igual/igual are valid from that cycle on.
  estado_t          r_state;
  estado_t          w_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic             r_p;
  logic             r_menor_igual;
  logic             w_tc;
  logic             w_clr;
  logic             w_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    Ai_o   = 1'b0;
    Bi_o   = 1'b0;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        w_en = 1'b1;
        Ai_o = r_sh_a[0];
        Bi_o = r_sh_b[0];
        if (w_tc) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  contador_bits #(.WIDTH(WIDTH)) u_contador (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_tc    (w_tc)
  );

  // The result is captured from P_i on the last RUN edge so it is already
  // valid while done is high; DONE re-latches the same value from r_p.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_p           <= ESTADO_A;
      r_menor_igual <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sh_a <= A;
            r_sh_b <= B;
            r_p    <= ESTADO_A;
          end
        end
        RUN: begin
          r_sh_a <= r_sh_a >> 1;
          r_sh_b <= r_sh_b >> 1;
          r_p    <= P_i;
          if (w_tc) r_menor_igual <= P_i;
        end
        DONE: r_menor_igual <= r_p;
        default: ;
      endcase
    end
  end

`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
  logic r_eq;
  logic r_igual;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_eq    <= 1'b0;
      r_igual <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) r_eq <= 1'b1;
        RUN: begin
          r_eq <= r_eq & (Ai_o == Bi_o);
          if (w_tc) r_igual <= r_eq & (Ai_o == Bi_o);
        end
        DONE: r_igual <= r_eq;
        default: ;
      endcase
    end
  end

  assign igual = r_igual;
`endif

  assign p_o         = r_p;
  assign menor_igual = r_menor_igual;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_comparador_serial.sv
// Bench for comparador_serial (WIDTH=8): behavioural cell on P_i, arithmetic
// reference model checked every cycle, plus directed literal checks.
module tb_comparador_serial;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ai_o;
  logic             Bi_o;
  logic             p_o;
  logic             P_i;
  logic             busy;
  logic             done;
  logic             menor_igual;
  logic             igual;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [1:0] exp_q[$];

  comparador_serial #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .Ai_o        (Ai_o),
    .Bi_o        (Bi_o),
    .p_o         (p_o),
    .P_i         (P_i),
    .busy        (busy),
    .done        (done),
    .menor_igual (menor_igual),
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
    .igual       (igual),
`endif
    .dbg_state   (dbg_state)
  );

`ifndef COMPARADOR_SERIAL_IGUALDAD_EN
  assign igual = 1'b0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Combinational cell: smaller bit -> state a, larger bit -> state b, equal keeps.
  always_comb begin
    if (Ai_o == Bi_o) P_i = p_o;
    else              P_i = Bi_o;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic prefix_le(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input int n);
    int unsigned ua;
    int unsigned ub;
    int unsigned m;
    m  = (32'd1 << n) - 32'd1;
    ua = 32'(a) & m;
    ub = 32'(b) & m;
    return ua <= ub;
  endfunction

  // ---------------- reference model ----------------
  int               m_phase = 0;   // 0 idle, 1 comparing, 2 reporting
  int               m_k     = 0;
  logic [WIDTH-1:0] m_a     = '0;
  logic [WIDTH-1:0] m_b     = '0;
  logic             m_res   = 1'b0;
  logic             m_eq    = 1'b0;
  logic             m_p     = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_k     <= 0;
      m_res   <= 1'b0;
      m_eq    <= 1'b0;
      m_p     <= 1'b1;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_k     <= 0;
          m_a     <= A;
          m_b     <= B;
          m_p     <= 1'b1;
        end
        1: if (m_k == WIDTH - 1) begin
          m_phase <= 2;
          m_res   <= (m_a <= m_b);
          m_eq    <= (m_a == m_b);
          m_p     <= (m_a <= m_b);
        end else begin
          m_k <= m_k + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic       e_ai;
    logic       e_bi;
    logic       e_p;
    logic [1:0] e_r;
    if (chk_en) begin
      e_ai = (m_phase == 1) ? m_a[m_k] : 1'b0;
      e_bi = (m_phase == 1) ? m_b[m_k] : 1'b0;
      e_p  = (m_phase == 1) ? prefix_le(m_a, m_b, m_k) : m_p;
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("Ai_o", 32'(Ai_o), 32'(e_ai));
      chk("Bi_o", 32'(Bi_o), 32'(e_bi));
      chk("p_o", 32'(p_o), 32'(e_p));
      chk("menor_igual", 32'(menor_igual), 32'(m_res));
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
      chk("igual", 32'(igual), 32'(m_eq));
`endif
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", 32'(done), 32'd0);
        end else begin
          e_r = exp_q.pop_front();
          chk("sb_menor_igual", 32'(menor_igual), 32'(e_r[0]));
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
          chk("sb_igual", 32'(igual), 32'(e_r[1]));
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one comparison from IDLE and returns at the negedge of the done cycle.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int ncyc, output logic [WIDTH-1:0] cap_a,
                         output logic [WIDTH-1:0] cap_b);
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back({a == b, a <= b});
    tick();
    start = 1'b0;
    ncyc  = 0;
    cap_a = '0;
    cap_b = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n <= WIDTH) begin
        cap_a[n-1] = Ai_o;
        cap_b[n-1] = Bi_o;
      end
      if (done) begin
        ncyc = n;
        break;
      end
    end
    if (ncyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               ncyc;
    int               seen;
    logic [WIDTH-1:0] ca;
    logic [WIDTH-1:0] cb;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_menor_igual", 32'(menor_igual), 32'd0);
    chk("rst_Ai_o", 32'(Ai_o), 32'd0);
    chk("rst_Bi_o", 32'(Bi_o), 32'd0);
    chk("rst_p_o", 32'(p_o), 32'd1);
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
    chk("rst_igual", 32'(igual), 32'd0);
`endif
    tick();
    reset = 1'b0;
    tick();

    // Equal operands
    run_cmp(8'h05, 8'h05, ncyc, ca, cb);
    chk("t1_done_cycle", 32'(ncyc), 32'd9);
    chk("t1_menor_igual", 32'(menor_igual), 32'd1);
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
    chk("t1_igual", 32'(igual), 32'd1);
`endif
    tick();

    // MSB decides
    run_cmp(8'h80, 8'h7F, ncyc, ca, cb);
    chk("t2a_menor_igual", 32'(menor_igual), 32'd0);
`ifdef COMPARADOR_SERIAL_IGUALDAD_EN
    chk("t2a_igual", 32'(igual), 32'd0);
`endif
    tick();
    run_cmp(8'h00, 8'hFF, ncyc, ca, cb);
    chk("t2b_menor_igual", 32'(menor_igual), 32'd1);
    tick();

    // LSB alone decides; serial bit order
    run_cmp(8'h01, 8'h00, ncyc, ca, cb);
    chk("t3_menor_igual", 32'(menor_igual), 32'd0);
    chk("t3_bits_a", 32'(ca), 32'h01);
    chk("t3_bits_b", 32'(cb), 32'h00);
    tick();

    // Starts in RUN (cycle 3) and DONE (cycle 9) are ignored
    A     = 8'h10;
    B     = 8'h20;
    start = 1'b1;
    exp_q.push_back({1'b0, 1'b1});
    tick();                       // cycle 1
    start = 1'b0;
    tick();                       // cycle 2
    tick();                       // cycle 3
    A     = 8'hFF;
    B     = 8'h00;
    start = 1'b1;
    tick();                       // cycle 4
    start = 1'b0;
    repeat (5) tick();            // cycle 9
    A     = 8'hF0;
    B     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    chk("t4_done_c9", 32'(done), 32'd1);
    chk("t4_busy_c9", 32'(busy), 32'd1);
    chk("t4_menor_igual", 32'(menor_igual), 32'd1);
    tick();                       // cycle 10
    start = 1'b0;
    @(negedge clk);
    chk("t4_busy_c10", 32'(busy), 32'd0);
    chk("t4_done_c10", 32'(done), 32'd0);
    tick();

    // Reset in cycle 4 of RUN aborts the comparison
    A     = 8'hAA;
    B     = 8'h55;
    start = 1'b1;
    exp_q.push_back({1'b0, 1'b0});
    tick();                       // cycle 1
    start = 1'b0;
    repeat (3) tick();            // cycle 4
    reset = 1'b1;
    tick();                       // cycle 5
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_p_o", 32'(p_o), 32'd1);
    chk("t5_menor_igual", 32'(menor_igual), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("t5_no_done", 32'(seen), 32'd0);
    tick();
    run_cmp(8'h33, 8'h33, ncyc, ca, cb);
    chk("t5_restart_cycle", 32'(ncyc), 32'd9);
    chk("t5_restart_menor_igual", 32'(menor_igual), 32'd1);
    tick();

    // Back-to-back: second start in the first IDLE cycle after done
    run_cmp(8'h7F, 8'h80, ncyc, ca, cb);
    chk("t6a_menor_igual", 32'(menor_igual), 32'd1);
    tick();
    run_cmp(8'hC0, 8'h3F, ncyc, ca, cb);
    chk("t6b_cycles", 32'(ncyc), 32'd9);
    chk("t6b_menor_igual", 32'(menor_igual), 32'd0);
    tick();

    // Random comparisons with random idle gaps
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      run_cmp(ra, rb, ncyc, ca, cb);
      chk("rnd_cycles", 32'(ncyc), 32'd9);
      chk("rnd_bits_a", 32'(ca), 32'(ra));
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
